tcm_port_arbiter: RTL and testbench

//  Shares the single data/external port of the dual-port TCM RAM between the CPU data

---
 rtl/tcm_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_tcm_port_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tcm_port_arbiter.sv
// tcm_port_arbiter: shares the TCM data/external RAM port between the CPU data
// interface and the AXI-to-pmem converter. CPU wins by default; a starved
// external requester gets promoted and then owns the port for a bounded burst.
module tcm_port_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int TAG_W        = 11,
    parameter int STARVE_LIMIT = 4,
    parameter int EXT_BURST    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // CPU data side
    input  logic              cpu_rd_i,
    input  logic [3:0]        cpu_wr_i,
    input  logic              cpu_op_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_wr_i,
    input  logic [TAG_W-1:0]  cpu_tag_i,
    output logic              cpu_accept_o,
    output logic              cpu_ack_o,
    output logic [TAG_W-1:0]  cpu_resp_tag_o,
    output logic [31:0]       cpu_data_rd_o,
    // External (AXI-to-pmem) side
    input  logic              ext_rd_i,
    input  logic [3:0]        ext_wr_i,
    input  logic [31:0]       ext_addr_i,
    input  logic [31:0]       ext_data_wr_i,
    output logic              ext_accept_o,
    output logic              ext_ack_o,
    output logic [31:0]       ext_data_rd_o,
    // RAM port
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_data_wr_o,
    output logic [3:0]        ram_wr_o,
    input  logic [31:0]       ram_data_rd_i
);

    localparam int WAIT_W  = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam int BURST_W = (EXT_BURST > 1) ? $clog2(EXT_BURST) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(STARVE_LIMIT - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(EXT_BURST - 1);

    typedef enum logic {CPU_PRI, EXT_PRI} state_t;

    state_t              state_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [BURST_W-1:0]  burst_q;

    logic cpu_req, ext_req;
    logic grant_cpu, grant_ext;

    assign cpu_req = cpu_rd_i | (|cpu_wr_i) | cpu_op_i;
    assign ext_req = ext_rd_i | (|ext_wr_i);

    // Grant decision: the prioritised side wins, the other only takes an idle port
    always_comb begin
        grant_cpu = 1'b0;
        grant_ext = 1'b0;
        if (state_q == EXT_PRI) begin
            grant_ext = ext_req;
            grant_cpu = !ext_req && cpu_req;
        end else begin
            grant_cpu = cpu_req;
            grant_ext = !cpu_req && ext_req;
        end
    end

    assign cpu_accept_o = grant_cpu;
    assign ext_accept_o = grant_ext;

    // RAM port mux; idle cycles park the address on the CPU side with writes off
    always_comb begin
        ram_addr_o    = cpu_addr_i[ADDR_W+1:2];
        ram_data_wr_o = cpu_data_wr_i;
        ram_wr_o      = 4'b0;
        if (grant_ext) begin
            ram_addr_o    = ext_addr_i[ADDR_W+1:2];
            ram_data_wr_o = ext_data_wr_i;
            ram_wr_o      = ext_wr_i;
        end else if (grant_cpu) begin
            ram_wr_o      = cpu_wr_i;
        end
    end

    // RAM read data is already registered, so both sides see it directly
    assign cpu_data_rd_o = ram_data_rd_i;
    assign ext_data_rd_o = ram_data_rd_i;

    // Priority FSM with starvation and burst counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CPU_PRI;
            wait_q  <= '0;
            burst_q <= '0;
        end else begin
            case (state_q)
                CPU_PRI: begin
                    burst_q <= '0;
                    if (ext_req && !grant_ext) begin
                        if (wait_q == WAIT_MAX) begin
                            state_q <= EXT_PRI;
                            wait_q  <= '0;
                        end else begin
                            wait_q  <= wait_q + 1'b1;
                        end
                    end else begin
                        wait_q <= '0;
                    end
                end
                EXT_PRI: begin
                    wait_q <= '0;
                    if (ext_req && burst_q != BURST_MAX) begin
                        burst_q <= burst_q + 1'b1;
                    end else begin
                        // burst exhausted or external side went quiet
                        state_q <= CPU_PRI;
                        burst_q <= '0;
                    end
                end
                default: begin
                    state_q <= CPU_PRI;
                    wait_q  <= '0;
                    burst_q <= '0;
                end
            endcase
        end
    end

    // Response strobes one cycle after grant, lining up with RAM read data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpu_ack_o      <= 1'b0;
            ext_ack_o      <= 1'b0;
            cpu_resp_tag_o <= '0;
        end else begin
            cpu_ack_o <= grant_cpu;
            ext_ack_o <= grant_ext;
            if (grant_cpu)
                cpu_resp_tag_o <= cpu_tag_i;
        end
    end

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Directed bench for tcm_port_arbiter with default parameters.
module tb_tcm_port_arbiter;

    localparam int ADDR_W = 14;
    localparam int TAG_W  = 11;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              cpu_rd_i;
    logic [3:0]        cpu_wr_i;
    logic              cpu_op_i;
    logic [31:0]       cpu_addr_i;
    logic [31:0]       cpu_data_wr_i;
    logic [TAG_W-1:0]  cpu_tag_i;
    logic              cpu_accept_o;
    logic              cpu_ack_o;
    logic [TAG_W-1:0]  cpu_resp_tag_o;
    logic [31:0]       cpu_data_rd_o;
    logic              ext_rd_i;
    logic [3:0]        ext_wr_i;
    logic [31:0]       ext_addr_i;
    logic [31:0]       ext_data_wr_i;
    logic              ext_accept_o;
    logic              ext_ack_o;
    logic [31:0]       ext_data_rd_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [31:0]       ram_data_wr_o;
    logic [3:0]        ram_wr_o;
    logic [31:0]       ram_data_rd_i;

    int n_chk  = 0;
    int n_pass = 0;

    tcm_port_arbiter #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .STARVE_LIMIT(4), .EXT_BURST(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i), .cpu_op_i(cpu_op_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_wr_i(cpu_data_wr_i), .cpu_tag_i(cpu_tag_i),
        .cpu_accept_o(cpu_accept_o), .cpu_ack_o(cpu_ack_o),
        .cpu_resp_tag_o(cpu_resp_tag_o), .cpu_data_rd_o(cpu_data_rd_o),
        .ext_rd_i(ext_rd_i), .ext_wr_i(ext_wr_i), .ext_addr_i(ext_addr_i),
        .ext_data_wr_i(ext_data_wr_i), .ext_accept_o(ext_accept_o),
        .ext_ack_o(ext_ack_o), .ext_data_rd_o(ext_data_rd_o),
        .ram_addr_o(ram_addr_o), .ram_data_wr_o(ram_data_wr_o),
        .ram_wr_o(ram_wr_o), .ram_data_rd_i(ram_data_rd_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // advance to just after the next rising edge
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        cpu_rd_i = 0; cpu_wr_i = 0; cpu_op_i = 0; cpu_addr_i = 0;
        cpu_data_wr_i = 0; cpu_tag_i = 0;
        ext_rd_i = 0; ext_wr_i = 0; ext_addr_i = 0; ext_data_wr_i = 0;
        ram_data_rd_i = 32'h1234_5678;
        tick; tick;
        chk("rst_cpu_ack", cpu_ack_o, 0);
        chk("rst_ext_ack", ext_ack_o, 0);
        chk("rst_tag", cpu_resp_tag_o, 0);
        chk("rst_cpu_acc", cpu_accept_o, 0);
        chk("rst_ext_acc", ext_accept_o, 0);
        rst_i = 1'b0;
        tick;

        // 1: CPU read
        cpu_rd_i = 1; cpu_addr_i = 32'h100; cpu_tag_i = 11'h2A;
        #1;
        chk("t1_cpu_acc", cpu_accept_o, 1);
        chk("t1_ext_acc", ext_accept_o, 0);
        chk("t1_addr", ram_addr_o, 14'h040);
        chk("t1_wr", ram_wr_o, 0);
        tick;
        cpu_rd_i = 0;
        #1;
        chk("t1_ack", cpu_ack_o, 1);
        chk("t1_tag", cpu_resp_tag_o, 11'h2A);
        chk("t1_rdata", cpu_data_rd_o, 32'h1234_5678);
        chk("idle_wr", ram_wr_o, 0);
        chk("idle_acc", cpu_accept_o, 0);

        // 2: external write
        ext_wr_i = 4'hF; ext_addr_i = 32'h200; ext_data_wr_i = 32'hDEAD_BEEF;
        #1;
        chk("t2_ext_acc", ext_accept_o, 1);
        chk("t2_cpu_acc", cpu_accept_o, 0);
        chk("t2_wr", ram_wr_o, 4'hF);
        chk("t2_addr", ram_addr_o, 14'h080);
        chk("t2_wdata", ram_data_wr_o, 32'hDEAD_BEEF);
        tick;
        ext_wr_i = 0;
        #1;
        chk("t2_ext_ack", ext_ack_o, 1);
        chk("t2_cpu_ack", cpu_ack_o, 0);
        ram_data_rd_i = 32'hCAFE_F00D;
        #1;
        chk("t2_rdata", ext_data_rd_o, 32'hCAFE_F00D);
        tick;

        // 3: starvation, CPU writes every cycle while ext waits
        cpu_wr_i = 4'b0011; cpu_data_wr_i = 32'hA5A5_0000; ext_rd_i = 1; ext_addr_i = 32'h400;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t3_deny%0d", i), {cpu_accept_o, ext_accept_o}, 2'b10);
            chk($sformatf("t3_wr%0d", i), ram_wr_o, 4'b0011);
            tick;
        end
        #1;
        chk("t3_promote", {cpu_accept_o, ext_accept_o}, 2'b01);
        chk("t3_addr", ram_addr_o, 14'h100);
        chk("t3_wr_ext", ram_wr_o, 0);

        // 4: burst of 4 ext grants, then CPU
        tick;
        for (int i = 1; i < 4; i++) begin
            #1;
            chk($sformatf("t4_burst%0d", i), {cpu_accept_o, ext_accept_o}, 2'b01);
            tick;
        end
        #1;
        chk("t4_cpu_back", {cpu_accept_o, ext_accept_o}, 2'b10);
        tick;
        ext_rd_i = 0;
        tick;

        // 5: ext drops mid-burst, CPU gets the drop cycle
        ext_rd_i = 1;
        for (int i = 0; i < 4; i++) tick;
        #1;
        chk("t5_grant1", {cpu_accept_o, ext_accept_o}, 2'b01);
        tick;
        #1;
        chk("t5_grant2", {cpu_accept_o, ext_accept_o}, 2'b01);
        tick;
        ext_rd_i = 0;
        #1;
        chk("t5_drop", {cpu_accept_o, ext_accept_o}, 2'b10);
        tick;
        ext_rd_i = 1;
        #1;
        chk("t5_cpu_pri", {cpu_accept_o, ext_accept_o}, 2'b10);
        tick;
        cpu_wr_i = 0; ext_rd_i = 0;
        tick;

        // 6: maintenance op, then reset mid-burst
        cpu_op_i = 1; cpu_tag_i = 11'h155;
        #1;
        chk("t6_op_acc", cpu_accept_o, 1);
        chk("t6_op_wr", ram_wr_o, 0);
        tick;
        cpu_op_i = 0;
        #1;
        chk("t6_op_ack", cpu_ack_o, 1);
        chk("t6_op_tag", cpu_resp_tag_o, 11'h155);
        cpu_rd_i = 1; ext_rd_i = 1;
        for (int i = 0; i < 4; i++) tick;
        #1;
        chk("t6_burst", ext_accept_o, 1);
        tick;
        #1;
        chk("t6_pre_ack", ext_ack_o, 1);
        rst_i = 1;
        #1;
        chk("t6_rst_ext_ack", ext_ack_o, 0);
        chk("t6_rst_cpu_ack", cpu_ack_o, 0);
        chk("t6_rst_tag", cpu_resp_tag_o, 0);
        rst_i = 0;
        #1;
        chk("t6_rst_cpu_pri", {cpu_accept_o, ext_accept_o}, 2'b10);
        tick;
        cpu_rd_i = 0; ext_rd_i = 0;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
